chip_capture: RTL and testbench

- Parameterised successor to the fixed 8-channel chip path.
- Watches N_CH parallel sample streams and triggers when any channel's magnitude reaches a threshold. It then emits one "chip" of cfg_len samples from the strongest channel, including up to PRE_DEPTH-1 pre-trigger samples.
- Sits between the sample mux outputs (sm_*) and the downstream chip buffer (chip_rdy handshake).
- Adds pre-trigger capture, strongest-channel selection, holdoff, framing flags and a missed-trigger counter.

---
 rtl/chip_pkg.sv | 27 ++
 rtl/chip_pre_ring.sv | 47 ++++
 rtl/chip_capture.sv | 223 ++++++++++++++++++++++
 tb/tb_chip_capture.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_pkg.sv
// chip_pkg: shared types, defaults and helpers for the chip capture path.
//   state_t      - capture FSM states (IDLE, WAIT, CAP, HOLD)
//   LEN_CHIP_DEF - nominal chip length used by the system configuration
//   mag_sat()    - saturating magnitude of a sign-extended sample
package chip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int LEN_CHIP_DEF = 4000;

    // x is a DW-bit sample sign-extended to 64 bits. The most negative value
    // has no positive twin in DW bits, so the result is clamped to
    // 2^(dw-1)-1 and always fits in dw-1 bits.
    function automatic logic [63:0] mag_sat(input logic [63:0] x, input int dw);
        logic [63:0] a;
        logic [63:0] lim;
        lim = (64'd1 << (dw - 1)) - 64'd1;
        a   = x[63] ? (~x + 64'd1) : x;
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/chip_pre_ring.sv
// chip_pre_ring: DEPTH-deep ring of full-width sample words used to reach
// back in time for pre-trigger samples.
//   clk_sys    in   system clock
//   rst        in   async active-high reset (clears the write pointer only)
//   wr_en_i    in   write strobe, one word per strobe
//   wr_data_i  in   word to write
//   delay_i    in   how many strobes back to read; 0 returns wr_data_i
//   rd_data_o  out  combinational read word
module chip_pre_ring
    import chip_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [W-1:0]     wr_data_i,
    input  logic [PTR_W-1:0] delay_i,
    output logic [W-1:0]     rd_data_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_addr;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
        end else if (wr_en_i) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // wr_ptr_q - 1 holds the most recent word, so wr_ptr_q - d is the word
    // written d strobes ago; DEPTH is a power of two so the subtraction wraps.
    assign rd_addr   = wr_ptr_q - delay_i;
    assign rd_data_o = (delay_i == '0) ? wr_data_i : mem_q[rd_addr];

endmodule

// File: rtl/chip_capture.sv
// chip_capture: watches N_CH sample streams, triggers when any channel's
// saturated magnitude reaches cfg_th, and emits one chip of cfg_len samples
// from the strongest channel including up to PRE_DEPTH-1 pre-trigger samples.
//   clk_sys, rst        clock, async active-high reset
//   sm_data, sm_vld     packed input samples (channel k at [k*DW +: DW]) + strobe
//   cfg_en/th/len/pre/holdoff  capture configuration
//   chip_rdy            downstream can accept a full chip
//   chip_d/vld/sop/eop  registered chip sample stream
//   chip_sel, chip_len  channel and length of the current or last chip
//   busy                FSM in CAP or HOLD
//   miss_cnt            saturating count of triggers dropped for chip_rdy=0
//
// state | meaning
// IDLE  | capture disabled, fill count held at 0
// WAIT  | armed, looking for an exceedance with enough ring history
// CAP   | emitting one sample per sm_vld from the selected channel
// HOLD  | ignoring a fixed number of sm_vld strobes after a chip
module chip_capture
    import chip_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int DW        = 16,
    parameter int PRE_DEPTH = 16,
    parameter int LEN_W     = 20,
    parameter int CH_W      = $clog2(N_CH)
) (
    input  logic                         clk_sys,
    input  logic                         rst,
    input  logic [N_CH*DW-1:0]           sm_data,
    input  logic                         sm_vld,
    input  logic                         cfg_en,
    input  logic [DW-2:0]                cfg_th,
    input  logic [LEN_W-1:0]             cfg_len,
    input  logic [$clog2(PRE_DEPTH)-1:0] cfg_pre,
    input  logic [LEN_W-1:0]             cfg_holdoff,
    input  logic                         chip_rdy,
    output logic [DW-1:0]                chip_d,
    output logic                         chip_vld,
    output logic                         chip_sop,
    output logic                         chip_eop,
    output logic [CH_W-1:0]              chip_sel,
    output logic [LEN_W-1:0]             chip_len,
    output logic                         busy,
    output logic [15:0]                  miss_cnt
);

    localparam int PTR_W = $clog2(PRE_DEPTH);

    state_t           state_q;
    logic [PTR_W-1:0] fill_q;
    logic [PTR_W-1:0] pre_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] hold_q;
    logic [CH_W-1:0]  sel_q;
    logic [DW-1:0]    chip_d_q;
    logic             chip_vld_q;
    logic             chip_sop_q;
    logic             chip_eop_q;
    logic             busy_q;
    logic [15:0]      miss_q;

    // Strongest hot channel; strict '>' keeps the lowest index on ties.
    logic [DW-2:0]    mag;
    logic [DW-2:0]    best_mag;
    logic [CH_W-1:0]  best_ch;
    logic             any_hot;

    always_comb begin
        mag      = '0;
        best_mag = '0;
        best_ch  = '0;
        any_hot  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            mag = (DW-1)'(mag_sat({{(64-DW){sm_data[k*DW+DW-1]}}, sm_data[k*DW +: DW]}, DW));
            if ((mag >= cfg_th) && (!any_hot || (mag > best_mag))) begin
                any_hot  = 1'b1;
                best_mag = mag;
                best_ch  = CH_W'(k);
            end
        end
    end

    logic [LEN_W-1:0] len_m1;
    logic [PTR_W-1:0] pre_trig;
    logic             trig;
    logic             take;
    logic             last;
    logic             emit;
    logic [PTR_W-1:0] rd_delay;
    logic [CH_W-1:0]  rd_sel;
    logic [N_CH*DW-1:0] ring_rd;
    logic [DW-1:0]    rd_word;
    state_t           post_state;

    // Pre-trigger depth can never exceed the chip, so a short chip still
    // ends on or after the trigger sample.
    assign len_m1   = cfg_len - 1'b1;
    assign pre_trig = (LEN_W'(cfg_pre) > len_m1) ? PTR_W'(len_m1) : cfg_pre;

    assign trig = (state_q == WAIT) && cfg_en && sm_vld && any_hot &&
                  (cfg_len != '0) && (fill_q >= cfg_pre);
    assign take = trig && chip_rdy;
    assign emit = take || ((state_q == CAP) && sm_vld);
    assign last = take ? (cfg_len == LEN_W'(1)) : (rem_q == LEN_W'(1));

    // The trigger strobe emits before len/pre/sel are latched, so it reads
    // the live values; later strobes use the latched ones.
    assign rd_delay = take ? pre_trig : pre_q;
    assign rd_sel   = take ? best_ch  : sel_q;
    assign rd_word  = ring_rd[rd_sel*DW +: DW];

    assign post_state = (cfg_holdoff != '0) ? HOLD : (cfg_en ? WAIT : IDLE);

    chip_pre_ring #(
        .W     (N_CH*DW),
        .DEPTH (PRE_DEPTH),
        .PTR_W (PTR_W)
    ) u_ring (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .wr_en_i   (sm_vld),
        .wr_data_i (sm_data),
        .delay_i   (rd_delay),
        .rd_data_o (ring_rd)
    );

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fill_q     <= '0;
            pre_q      <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            hold_q     <= '0;
            sel_q      <= '0;
            chip_d_q   <= '0;
            chip_vld_q <= 1'b0;
            chip_sop_q <= 1'b0;
            chip_eop_q <= 1'b0;
            busy_q     <= 1'b0;
            miss_q     <= '0;
        end else begin
            chip_vld_q <= emit;
            chip_sop_q <= take;
            chip_eop_q <= emit && last;
            if (emit) begin
                chip_d_q <= rd_word;
            end

            if (state_q == IDLE) begin
                fill_q <= '0;
            end else if (sm_vld && (fill_q != PTR_W'(PRE_DEPTH-1))) begin
                fill_q <= fill_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (cfg_en) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!cfg_en) begin
                        state_q <= IDLE;
                    end else if (trig) begin
                        if (chip_rdy) begin
                            sel_q <= best_ch;
                            len_q <= cfg_len;
                            pre_q <= pre_trig;
                            rem_q <= len_m1;
                            if (last) begin
                                state_q <= post_state;
                                hold_q  <= cfg_holdoff;
                                busy_q  <= (cfg_holdoff != '0);
                            end else begin
                                state_q <= CAP;
                                busy_q  <= 1'b1;
                            end
                        end else if (miss_q != 16'hFFFF) begin
                            miss_q <= miss_q + 1'b1;
                        end
                    end
                end
                CAP: begin
                    if (sm_vld) begin
                        if (last) begin
                            state_q <= post_state;
                            hold_q  <= cfg_holdoff;
                            busy_q  <= (cfg_holdoff != '0);
                        end else begin
                            rem_q <= rem_q - 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (sm_vld) begin
                        if (hold_q == LEN_W'(1)) begin
                            state_q <= cfg_en ? WAIT : IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign chip_d   = chip_d_q;
    assign chip_vld = chip_vld_q;
    assign chip_sop = chip_sop_q;
    assign chip_eop = chip_eop_q;
    assign chip_sel = sel_q;
    assign chip_len = len_q;
    assign busy     = busy_q;
    assign miss_cnt = miss_q;

endmodule

// File: tb/tb_chip_capture.sv
// tb_chip_capture: directed bench for chip_capture with N_CH=8, DW=16,
// PRE_DEPTH=16, cfg_len=10, cfg_pre=3, cfg_th=100 unless a step changes them.
module tb_chip_capture;

    localparam int N_CH      = 8;
    localparam int DW        = 16;
    localparam int PRE_DEPTH = 16;
    localparam int LEN_W     = 20;
    localparam int CH_W      = 3;

    logic                 clk_sys = 1'b0;
    logic                 rst = 1'b0;
    logic [N_CH*DW-1:0]   sm_data = '0;
    logic                 sm_vld = 1'b0;
    logic                 cfg_en = 1'b0;
    logic [DW-2:0]        cfg_th = 15'd100;
    logic [LEN_W-1:0]     cfg_len = 20'd10;
    logic [3:0]           cfg_pre = 4'd3;
    logic [LEN_W-1:0]     cfg_holdoff = '0;
    logic                 chip_rdy = 1'b1;
    logic [DW-1:0]        chip_d;
    logic                 chip_vld;
    logic                 chip_sop;
    logic                 chip_eop;
    logic [CH_W-1:0]      chip_sel;
    logic [LEN_W-1:0]     chip_len;
    logic                 busy;
    logic [15:0]          miss_cnt;

    chip_capture #(
        .N_CH(N_CH), .DW(DW), .PRE_DEPTH(PRE_DEPTH), .LEN_W(LEN_W), .CH_W(CH_W)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .sm_data(sm_data), .sm_vld(sm_vld),
        .cfg_en(cfg_en), .cfg_th(cfg_th), .cfg_len(cfg_len), .cfg_pre(cfg_pre),
        .cfg_holdoff(cfg_holdoff), .chip_rdy(chip_rdy), .chip_d(chip_d),
        .chip_vld(chip_vld), .chip_sop(chip_sop), .chip_eop(chip_eop),
        .chip_sel(chip_sel), .chip_len(chip_len), .busy(busy), .miss_cnt(miss_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int tests = 0;
    int fails = 0;
    int sidx  = 0;

    logic [DW-1:0]   q_d[$];
    logic            q_sop[$];
    logic            q_eop[$];
    logic [CH_W-1:0] q_sel[$];
    int              q_idx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        q_d.delete(); q_sop.delete(); q_eop.delete(); q_sel.delete(); q_idx.delete();
    endtask

    // One sm_vld strobe; any chip pulse it causes is visible just after the edge.
    task automatic strobe(input logic [N_CH*DW-1:0] d);
        @(negedge clk_sys);
        sm_data = d;
        sm_vld  = 1'b1;
        sidx++;
        @(posedge clk_sys);
        #1;
        sm_vld = 1'b0;
        if (chip_vld) begin
            q_d.push_back(chip_d);
            q_sop.push_back(chip_sop);
            q_eop.push_back(chip_eop);
            q_sel.push_back(chip_sel);
            q_idx.push_back(sidx);
        end
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) strobe('0);
    endtask

    function automatic logic [N_CH*DW-1:0] one(input int ch, input logic [DW-1:0] v);
        logic [N_CH*DW-1:0] d;
        d = '0;
        d[ch*DW +: DW] = v;
        return d;
    endfunction

    initial begin
        logic [N_CH*DW-1:0] d;
        int base;
        int eops;

        // reset
        #1 rst = 1'b1;
        #2;
        chk("rst_vld", chip_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miss", miss_cnt, 0);
        chk("rst_len", chip_len, 0);
        chk("rst_d", chip_d, 0);
        @(negedge clk_sys);
        rst = 1'b0;

        // basic capture: ch5 = n, 500 at n=20
        cfg_en = 1'b1;
        repeat (2) @(posedge clk_sys);
        clr();
        base = sidx;
        for (int n = 0; n < 30; n++) begin
            strobe(one(5, (n == 20) ? 16'd500 : 16'(n)));
            if (n == 22) chk("busy_cap", busy, 1);
        end
        chk("basic_cnt", q_d.size(), 10);
        if (q_d.size() > 0) chk("basic_first_idx", q_idx[0], base + 21);
        for (int i = 0; i < 10; i++) begin
            if (i < q_d.size()) begin
                chk("basic_d", q_d[i], (i == 3) ? 500 : 17 + i);
                chk("basic_sop", q_sop[i], (i == 0) ? 1 : 0);
                chk("basic_eop", q_eop[i], (i == 9) ? 1 : 0);
                chk("basic_sel", q_sel[i], 5);
            end
        end
        chk("basic_busy_done", busy, 0);
        chk("basic_len", chip_len, 10);

        // tie A: |-300| == |300|, lower index wins
        clr();
        d = '0;
        d[2*DW +: DW] = 16'hFED4;
        d[6*DW +: DW] = 16'd300;
        strobe(d);
        zeros(9);
        chk("tieA_cnt", q_d.size(), 10);
        if (q_d.size() == 10) begin
            chk("tieA_sel", q_sel[0], 2);
            chk("tieA_trig_d", q_d[3], 16'hFED4);
        end

        // tie B: -32768 saturates to 32767
        clr();
        d = '0;
        d[3*DW +: DW] = 16'h8000;
        d[1*DW +: DW] = 16'h7FFF;
        strobe(d);
        zeros(9);
        chk("tieB_cnt", q_d.size(), 10);
        if (q_d.size() == 10) begin
            chk("tieB_sel", q_sel[0], 1);
            chk("tieB_trig_d", q_d[3], 16'h7FFF);
        end

        // threshold boundary: 99 and -99 are below, 100 is hot
        clr();
        strobe(one(0, 16'd99));
        strobe(one(0, 16'hFF9D));
        chk("below_th", q_d.size(), 0);

        // backpressure: first trigger dropped, second two strobes later taken
        chip_rdy = 1'b0;
        strobe(one(0, 16'd100));
        chk("bp_no_vld", q_d.size(), 0);
        chk("bp_miss", miss_cnt, 1);
        chip_rdy = 1'b1;
        strobe('0);
        strobe(one(0, 16'd100));
        zeros(9);
        chk("bp_cnt", q_d.size(), 10);
        if (q_d.size() == 10) begin
            chk("bp_missed_sample_in_ring", q_d[1], 100);
            chk("bp_trig_d", q_d[3], 100);
            chk("bp_eop", q_eop[9], 1);
        end
        chk("bp_miss_after", miss_cnt, 1);

        // holdoff of 5 strobes
        cfg_holdoff = 20'd5;
        clr();
        strobe(one(4, 16'd150));
        zeros(9);
        chk("ho_chip1_cnt", q_d.size(), 10);
        chk("ho_busy_hold", busy, 1);
        clr();
        zeros(2);
        strobe(one(4, 16'd150));
        chk("ho_ignored", q_d.size(), 0);
        zeros(2);
        cfg_holdoff = '0;
        strobe(one(4, 16'd150));
        chk("ho_second_taken", q_d.size(), 1);
        if (q_d.size() == 1) chk("ho_first_d", q_d[0], 150);
        zeros(9);
        chk("ho_chip2_cnt", q_d.size(), 10);
        chk("ho_miss", miss_cnt, 1);
        chk("ho_busy_done", busy, 0);

        // fill: exceedance on 2nd strobe after enable is ignored; len=1 chip
        cfg_en = 1'b0;
        repeat (2) @(posedge clk_sys);
        strobe('0);
        cfg_en = 1'b1;
        repeat (2) @(posedge clk_sys);
        cfg_len = 20'd1;
        clr();
        strobe('0);
        strobe(one(0, 16'd200));
        chk("fill_ignored", q_d.size(), 0);
        chk("fill_miss", miss_cnt, 1);
        strobe('0);
        strobe(one(0, 16'd200));
        chk("len1_cnt", q_d.size(), 1);
        if (q_d.size() == 1) begin
            chk("len1_d", q_d[0], 200);
            chk("len1_sop", q_sop[0], 1);
            chk("len1_eop", q_eop[0], 1);
        end
        chk("len1_len", chip_len, 1);

        // cfg_len = 0 never triggers, not even as a miss
        cfg_len = '0;
        chip_rdy = 1'b0;
        clr();
        repeat (3) strobe(one(0, 16'd200));
        chip_rdy = 1'b1;
        strobe(one(0, 16'd200));
        chk("len0_cnt", q_d.size(), 0);
        chk("len0_miss", miss_cnt, 1);

        // reset after 4 emitted samples
        cfg_len = 20'd10;
        clr();
        strobe(one(7, 16'd300));
        zeros(3);
        chk("rstcap_cnt", q_d.size(), 4);
        rst = 1'b1;
        #1;
        chk("rstcap_vld", chip_vld, 0);
        chk("rstcap_busy", busy, 0);
        chk("rstcap_miss", miss_cnt, 0);
        chk("rstcap_eop_out", chip_eop, 0);
        eops = 0;
        foreach (q_eop[i]) eops += int'(q_eop[i]);
        chk("rstcap_no_eop", eops, 0);
        @(negedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys);
        rst = 1'b0;
        repeat (2) @(posedge clk_sys);
        clr();
        repeat (3) strobe(one(7, 16'd300));
        chk("refill_none", q_d.size(), 0);
        strobe(one(7, 16'd300));
        chk("refill_trig", q_d.size(), 1);
        if (q_d.size() == 1) begin
            chk("refill_sop", q_sop[0], 1);
            chk("refill_d", q_d[0], 300);
            chk("refill_sel", q_sel[0], 7);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
